// File: rtl/eee_stream_hsmooth_if.sv
// Avalon-ST beat bundle: 24-bit data with valid/ready and packet delimiters.
// The sink side of a block uses the slave modport, the source side the master modport.
interface eee_stream_hsmooth_if;
  logic [23:0] data;
  logic        valid;
  logic        ready;
  logic        sop;
  logic        eop;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/eee_stream_hsmooth.sv
// Horizontal [1 2 1]/4 smoothing of R, G and B on an Avalon-ST video stream.
// Control packets, and video packets received with enable low, pass through unchanged.
module eee_stream_hsmooth #(
  parameter logic [10:0] IMAGE_W = 11'd640
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  eee_stream_hsmooth_if.slave         sink,
  eee_stream_hsmooth_if.master        source
);

  typedef enum logic [1:0] {StIdle, StPass, StVideo, StFlush} state_e;

  state_e      r_state, w_state_d;
  logic        r_src_valid, r_src_sop, r_src_eop;
  logic [23:0] r_src_data;
  logic [23:0] r_prev, r_held;
  logic        r_held_valid, r_held_col0;
  logic [10:0] r_x;

  logic        w_out_free, w_accept;
  logic        w_emit, w_out_sop, w_out_eop;
  logic [23:0] w_out_data, w_left, w_right;
  logic        w_restart, w_pixel, w_flush;

  // Per channel (L + 2C + R + 2) >> 2; the 10-bit sum never exceeds 1022.
  function automatic logic [23:0] smooth(input logic [23:0] l, input logic [23:0] c,
                                         input logic [23:0] r);
    logic [23:0] res;
    logic [9:0]  sum;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = {2'b00, l[8*ch +: 8]} + {1'b0, c[8*ch +: 8], 1'b0} + {2'b00, r[8*ch +: 8]} + 10'd2;
      res[8*ch +: 8] = sum[9:2];
    end
    return res;
  endfunction

  assign w_out_free = ~r_src_valid | source.ready;
  assign sink.ready = w_out_free & (r_state != StFlush);
  assign w_accept   = sink.valid & sink.ready;

  // Row edges replicate the centre pixel; r_x == 0 means held closed its row.
  assign w_left  = r_held_col0 ? r_held : r_prev;
  assign w_right = (r_x == 11'd0) ? r_held : sink.data;

  always_comb begin
    w_state_d  = r_state;
    w_emit     = 1'b0;
    w_out_data = sink.data;
    w_out_sop  = 1'b0;
    w_out_eop  = sink.eop;
    w_restart  = 1'b0;
    w_pixel    = 1'b0;
    w_flush    = 1'b0;
    unique case (r_state)
      StIdle: w_restart = w_accept & sink.sop;
      StPass: begin
        if (w_accept) begin
          if (sink.sop) begin
            w_restart = 1'b1;
          end else begin
            w_emit = 1'b1;
            if (sink.eop) w_state_d = StIdle;
          end
        end
      end
      StVideo: begin
        if (w_accept) begin
          if (sink.sop) begin
            w_restart = 1'b1;
          end else begin
            w_pixel    = 1'b1;
            w_emit     = r_held_valid;
            w_out_data = smooth(w_left, r_held, w_right);
            w_out_eop  = 1'b0;
            if (sink.eop) w_state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (w_out_free) begin
          w_flush    = 1'b1;
          w_emit     = 1'b1;
          w_out_data = smooth(w_left, r_held, r_held);
          w_out_eop  = 1'b1;
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // A sop beat always starts a fresh packet, abandoning any unfinished one.
    if (w_restart) begin
      w_emit     = 1'b1;
      w_out_data = sink.data;
      w_out_sop  = 1'b1;
      w_out_eop  = sink.eop;
      if (sink.eop) begin
        w_state_d = StIdle;
      end else if ((sink.data[3:0] == 4'h0) && enable) begin
        w_state_d = StVideo;
      end else begin
        w_state_d = StPass;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_src_valid  <= 1'b0;
      r_src_data   <= '0;
      r_src_sop    <= 1'b0;
      r_src_eop    <= 1'b0;
      r_prev       <= '0;
      r_held       <= '0;
      r_held_valid <= 1'b0;
      r_held_col0  <= 1'b0;
      r_x          <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_out_free) begin
        r_src_valid <= w_emit;
        if (w_emit) begin
          r_src_data <= w_out_data;
          r_src_sop  <= w_out_sop;
          r_src_eop  <= w_out_eop;
        end
      end
      if (w_restart) begin
        r_held_valid <= 1'b0;
        r_x          <= '0;
      end else if (w_pixel) begin
        r_prev       <= r_held;
        r_held       <= sink.data;
        r_held_valid <= 1'b1;
        r_held_col0  <= (r_x == 11'd0);
        r_x          <= (r_x == IMAGE_W - 11'd1) ? 11'd0 : r_x + 11'd1;
      end else if (w_flush) begin
        r_held_valid <= 1'b0;
      end
    end
  end

  assign source.valid = r_src_valid;
  assign source.data  = r_src_data;
  assign source.sop   = r_src_sop;
  assign source.eop   = r_src_eop;

endmodule

// File: tb/tb_eee_stream_hsmooth.sv
// Scoreboard bench for eee_stream_hsmooth: a packet-level reference model fills the
// expected queue, and an independent monitor pops and compares every output beat.
module tb_eee_stream_hsmooth;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;

  eee_stream_hsmooth_if snk ();
  eee_stream_hsmooth_if src ();

  eee_stream_hsmooth #(.IMAGE_W(11'(W))) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .sink    (snk),
    .source  (src)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int gap_pct = 0;
  int rdy_pct = 100;
  logic hold_low = 1'b0;
  logic [25:0] exp_q[$];  // {sop, eop, data}
  logic [23:0] pkt[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [23:0] ref_f(input logic [23:0] l, input logic [23:0] c,
                                        input logic [23:0] r);
    logic [23:0] o;
    int v;
    o = '0;
    for (int ch = 0; ch < 3; ch++) begin
      v = (int'(l[8*ch +: 8]) + 2 * int'(c[8*ch +: 8]) + int'(r[8*ch +: 8]) + 2) / 4;
      o[8*ch +: 8] = 8'(v);
    end
    return o;
  endfunction

  // Expected output of one packet: header + pkt[], term = packet ends with eop.
  task automatic model_push(input logic [23:0] desc, input logic en, input logic term);
    int n, col;
    logic video, last;
    logic [23:0] l, r;
    n = pkt.size();
    video = (desc[3:0] == 4'h0) && en;
    exp_q.push_back({1'b1, term && (n == 0), desc});
    for (int i = 0; i < n; i++) begin
      last = term && (i == n - 1);
      if (!video) begin
        exp_q.push_back({1'b0, last, pkt[i]});
      end else if (term || i < n - 1) begin
        col = i % W;
        l = (col == 0) ? pkt[i] : pkt[i-1];
        r = (col == W - 1 || i == n - 1) ? pkt[i] : pkt[i+1];
        exp_q.push_back({1'b0, last, ref_f(l, pkt[i], r)});
      end
    end
  endtask

  // Called and returns at posedge+1; returns in the cycle after the beat transferred.
  task automatic send(input logic [23:0] d, input logic s, input logic e, input logic en);
    int g, k;
    logic acc;
    g = 0;
    while (g < 4 && $urandom_range(99) < gap_pct) begin
      @(posedge clk);
      #1;
      g++;
    end
    snk.valid = 1'b1;
    snk.data  = d;
    snk.sop   = s;
    snk.eop   = e;
    enable    = en;
    k = 0;
    forever begin
      @(negedge clk);
      acc = snk.ready;
      @(posedge clk);
      #1;
      if (acc) break;
      k++;
      if (k > 2000) begin
        n_errors++;
        $display("FAIL sink_accept_timeout: beat %h never accepted", d);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "sink stalled");
      end
    end
    snk.valid = 1'b0;
    enable    = 1'($urandom_range(1));
  endtask

  task automatic send_beats(input logic [23:0] desc, input logic en, input logic term);
    int n;
    n = pkt.size();
    send(desc, 1'b1, term && (n == 0), en);
    for (int i = 0; i < n; i++) send(pkt[i], 1'b0, term && (i == n - 1), 1'($urandom_range(1)));
  endtask

  task automatic send_packet(input logic [23:0] desc, input logic en, input logic term);
    model_push(desc, en, term);
    send_beats(desc, en, term);
  endtask

  task automatic rand_packet(input logic term);
    logic [23:0] desc;
    int n;
    pkt.delete();
    desc = 24'($urandom);
    if ($urandom_range(4) == 0) begin
      desc[3:0] = 4'($urandom_range(15, 1));
      n = $urandom_range(3);
    end else begin
      desc[3:0] = 4'h0;
      n = $urandom_range(6 * W);
    end
    for (int i = 0; i < n; i++) pkt.push_back(24'($urandom));
    send_packet(desc, 1'($urandom_range(1)), term);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    src.ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      src.ready = !hold_low && ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor: a beat shown with valid&ready at the negedge transfers on the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (src.valid && !src.ready) check("sink_ready_when_full", 32'(snk.ready), 32'd0);
        if (src.valid && src.ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got %h with sop=%b eop=%b, none expected",
                     src.data, src.sop, src.eop);
          end else begin
            check("out_beat", 32'({src.sop, src.eop, src.data}), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int rin[4];
    int rout[4];
    rin  = '{0, 40, 80, 120};
    rout = '{10, 40, 80, 110};
    snk.valid = 1'b0;
    snk.data  = '0;
    snk.sop   = 1'b0;
    snk.eop   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(src.valid), 32'd0);
    check("reset_data", 32'(src.data), 32'd0);
    check("reset_sop", 32'(src.sop), 32'd0);
    check("reset_eop", 32'(src.eop), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_sink_ready", 32'(snk.ready), 32'd1);

    // Control packet: identical output, one cycle latency.
    pkt = '{24'h123456, 24'hABCDEF};
    model_push(24'h00000F, 1'b1, 1'b1);
    send(24'h00000F, 1'b1, 1'b0, 1'b1);
    check("pass_latency_valid", 32'(src.valid), 32'd1);
    check("pass_latency_data", 32'(src.data), 32'h00000F);
    send(pkt[0], 1'b0, 1'b0, 1'b0);
    send(pkt[1], 1'b0, 1'b1, 1'b1);
    wait_drain("drain_ctrl");

    // Two-row red ramp, hand-computed expectations.
    exp_q.push_back({2'b10, 24'h0});
    for (int row = 0; row < 2; row++)
      for (int i = 0; i < 4; i++)
        exp_q.push_back({1'b0, (row == 1 && i == 3), 8'(rout[i]), 16'h0});
    send(24'h0, 1'b1, 1'b0, 1'b1);
    for (int row = 0; row < 2; row++)
      for (int i = 0; i < 4; i++)
        send({8'(rin[i]), 16'h0}, 1'b0, (row == 1 && i == 3), 1'($urandom_range(1)));
    check("flush_sink_ready", 32'(snk.ready), 32'd0);
    wait_drain("drain_ramp");

    // Same frame in bypass.
    pkt.delete();
    for (int row = 0; row < 2; row++)
      for (int i = 0; i < 4; i++) pkt.push_back({8'(rin[i]), 16'h0});
    send_packet(24'h0, 1'b0, 1'b1);
    wait_drain("drain_bypass");

    // Saturated frame.
    pkt.delete();
    for (int i = 0; i < 2 * W; i++) pkt.push_back(24'hFFFFFF);
    send_packet(24'h0, 1'b1, 1'b1);
    wait_drain("drain_white");

    // Lost eop in a video and in a control packet, then a normal frame.
    pkt.delete();
    for (int i = 0; i < 6; i++) pkt.push_back(24'($urandom));
    send_packet(24'h000010, 1'b1, 1'b0);
    pkt = '{24'h111111, 24'h222222};
    send_packet(24'h000003, 1'b1, 1'b0);
    pkt.delete();
    for (int i = 0; i < 5; i++) pkt.push_back(24'($urandom));
    send_packet(24'h000000, 1'b1, 1'b1);
    wait_drain("drain_lost_eop");

    // Random traffic with input gaps and output backpressure.
    gap_pct = 50;
    rdy_pct = 50;
    for (int p = 0; p < 30; p++) rand_packet(($urandom_range(9) != 0) || (p == 29));
    wait_drain("drain_random");

    // Reset mid-row while the output register is stalled full.
    gap_pct = 0;
    rdy_pct = 100;
    repeat (2) @(posedge clk);
    #1;
    pkt.delete();
    for (int i = 0; i < 6; i++) pkt.push_back(24'($urandom));
    send_packet(24'h0, 1'b1, 1'b0);
    hold_low = 1'b1;
    @(posedge clk);
    #3;
    check("stall_holds_valid", 32'(src.valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(src.valid), 32'd0);
    check("midreset_data", 32'(src.data), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("inreset_valid", 32'(src.valid), 32'd0);
    reset_n = 1'b1;
    hold_low = 1'b0;
    gap_pct = 30;
    rdy_pct = 60;
    @(posedge clk);
    #1;
    pkt.delete();
    for (int i = 0; i < 3 * W; i++) pkt.push_back(24'($urandom));
    send_packet(24'h000020, 1'b1, 1'b1);
    wait_drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
